// File: rtl/multicycle_control_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_if
//  Purpose  : Bundle of opcode/handshake inputs and datapath control outputs
//             exchanged between the multi-cycle control unit and its datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int ALUOP_W = 2
);
  // Datapath -> control
  logic [5:0]         opCode;
  logic               memReady;
  // Control -> datapath
  logic               pcWrite;
  logic               branch;
  logic               irWrite;
  logic               iorD;
  logic               memRead;
  logic               memWrite;
  logic               memToReg;
  logic               regDst;
  logic               regWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUop;
  logic [1:0]         PCSrc;
  logic               instrDone;
  logic               illegalOp;
  logic               memError;

  // The control unit itself.
  modport slave (
    input  opCode, memReady,
    output pcWrite, branch, irWrite, iorD, memRead, memWrite, memToReg,
           regDst, regWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc,
           instrDone, illegalOp, memError
  );

  // The datapath (or a bench) driving opcode and memory readiness.
  modport master (
    output opCode, memReady,
    input  pcWrite, branch, irWrite, iorD, memRead, memWrite, memToReg,
           regDst, regWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc,
           instrDone, illegalOp, memError
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle MIPS control FSM (R-type, lw, sw, beq, j, addi)
//             with optional memory-ready handshake and wait timeout.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_LIMIT    = 15,
  parameter int ALUOP_W       = 2
) (
  input  wire clk,
  input  wire rst_n,
  multicycle_control_if.slave ctl
);

  localparam int            CNT_W   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(WAIT_LIMIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         op_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_rdy;
  logic               w_timeout;
  logic               w_wait_state;

  logic               w_pc_write, w_branch, w_ir_write, w_iord;
  logic               w_mem_read, w_mem_write, w_mem_to_reg, w_reg_dst;
  logic               w_reg_write, w_src_a, w_done, w_illegal, w_mem_err;
  logic [1:0]         w_src_b, w_alu_op, w_pc_src;

  // Without the handshake every memory access is treated as completing at once.
  if (MEM_HANDSHAKE) begin : g_handshake
    assign w_rdy = ctl.memReady;
  end else begin : g_no_handshake
    assign w_rdy = 1'b1;
  end

  // Timeout fires only when the wait counter has reached the limit and memory
  // is still not ready; a ready in the limit cycle wins.
  if (WAIT_LIMIT > 0) begin : g_timeout
    assign w_timeout = !w_rdy && (cnt_q == LIMIT_V);
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

  // Counter grows only while parked in a wait state; any exit, timeout or
  // re-entry leaves it cleared for the next wait state.
  always_comb begin
    cnt_d = '0;
    if (w_wait_state && !w_rdy && !w_timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) begin
        op_q <= ctl.opCode;
      end
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    state_d      = state_q;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    w_mem_err    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = 2'b01;
        if (w_rdy) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          state_d    = S_DECODE;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        w_src_b = 2'b11;
        case (ctl.opCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (w_rdy) begin
          state_d = S_MEMWB;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (w_rdy) begin
          w_done  = 1'b1;
          state_d = S_FETCH;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_src_a  = 1'b1;
        w_alu_op = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a  = 1'b1;
        w_alu_op = 2'b01;
        w_pc_src = 2'b01;
        w_branch = 1'b1;
        w_done   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while reset is held so no strobe survives it.
  assign ctl.pcWrite   = rst_n & w_pc_write;
  assign ctl.branch    = rst_n & w_branch;
  assign ctl.irWrite   = rst_n & w_ir_write;
  assign ctl.iorD      = rst_n & w_iord;
  assign ctl.memRead   = rst_n & w_mem_read;
  assign ctl.memWrite  = rst_n & w_mem_write;
  assign ctl.memToReg  = rst_n & w_mem_to_reg;
  assign ctl.regDst    = rst_n & w_reg_dst;
  assign ctl.regWrite  = rst_n & w_reg_write;
  assign ctl.ALUSrcA   = rst_n & w_src_a;
  assign ctl.ALUSrcB   = rst_n ? w_src_b : 2'b00;
  assign ctl.ALUop     = rst_n ? ALUOP_W'(w_alu_op) : '0;
  assign ctl.PCSrc     = rst_n ? w_pc_src : 2'b00;
  assign ctl.instrDone = rst_n & w_done;
  assign ctl.illegalOp = rst_n & w_illegal;
  assign ctl.memError  = rst_n & w_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control using a per-opcode
//             step-table reference model and randomized memReady/opcodes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam int LIM = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Control word layout: {pcWrite,branch,irWrite,iorD,memRead,memWrite,
  // memToReg,regDst,regWrite,ALUSrcA,ALUSrcB[1:0],ALUop[1:0],PCSrc[1:0],
  // instrDone,illegalOp,memError}
  localparam logic [18:0] M_PCW  = 19'd1 << 18;
  localparam logic [18:0] M_BR   = 19'd1 << 17;
  localparam logic [18:0] M_IRW  = 19'd1 << 16;
  localparam logic [18:0] M_IORD = 19'd1 << 15;
  localparam logic [18:0] M_MRD  = 19'd1 << 14;
  localparam logic [18:0] M_MWR  = 19'd1 << 13;
  localparam logic [18:0] M_M2R  = 19'd1 << 12;
  localparam logic [18:0] M_RDST = 19'd1 << 11;
  localparam logic [18:0] M_RW   = 19'd1 << 10;
  localparam logic [18:0] M_SA   = 19'd1 << 9;
  localparam logic [18:0] M_DONE = 19'd1 << 2;
  localparam logic [18:0] M_ILL  = 19'd1 << 1;
  localparam logic [18:0] M_MERR = 19'd1 << 0;

  // Expected control word of each instruction step (ALUSrcB at <<7,
  // ALUop at <<5, PCSrc at <<3).
  localparam logic [18:0] W_FETCH = M_MRD | (19'd1 << 7);
  localparam logic [18:0] W_DEC   = (19'd3 << 7);
  localparam logic [18:0] W_MADR  = M_SA | (19'd2 << 7);
  localparam logic [18:0] W_MRD   = M_IORD | M_MRD;
  localparam logic [18:0] W_MWB   = M_M2R | M_RW | M_DONE;
  localparam logic [18:0] W_MWR   = M_IORD | M_MWR;
  localparam logic [18:0] W_EXEC  = M_SA | (19'd2 << 5);
  localparam logic [18:0] W_AWB   = M_RDST | M_RW | M_DONE;
  localparam logic [18:0] W_BR    = M_SA | M_BR | M_DONE | (19'd1 << 5) | (19'd1 << 3);
  localparam logic [18:0] W_AEX   = M_SA | (19'd2 << 7);
  localparam logic [18:0] W_AIWB  = M_RW | M_DONE;
  localparam logic [18:0] W_J     = M_PCW | M_DONE | (19'd2 << 3);

  // Step kinds: 0 single cycle, 1 fetch wait (irWrite/pcWrite on ready),
  // 2 plain memory wait, 3 store wait (instrDone on ready).
  localparam int K_ONE = 0;
  localparam int K_FW  = 1;
  localparam int K_MW  = 2;
  localparam int K_SW  = 3;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_control_if #(.ALUOP_W(2)) ctl();

  multicycle_control #(
    .MEM_HANDSHAKE (1'b1),
    .WAIT_LIMIT    (LIM),
    .ALUOP_W       (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [18:0] seq_w[$];
  int          seq_k[$];
  bit          rdy_pat[$];
  bit          rand_rdy;

  int g_cyc, g_irw, g_mwr, g_merr, g_ill, g_rw, g_pcw, g_mrd;
  int done_q[$];

  function automatic logic [18:0] obs_w();
    return {ctl.pcWrite, ctl.branch, ctl.irWrite, ctl.iorD, ctl.memRead,
            ctl.memWrite, ctl.memToReg, ctl.regDst, ctl.regWrite, ctl.ALUSrcA,
            ctl.ALUSrcB, ctl.ALUop, ctl.PCSrc, ctl.instrDone, ctl.illegalOp,
            ctl.memError};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  task automatic clr();
    g_cyc = 0; g_irw = 0; g_mwr = 0; g_merr = 0;
    g_ill = 0; g_rw = 0; g_pcw = 0; g_mrd = 0;
    done_q.delete();
  endtask

  task automatic build_seq(input logic [5:0] op);
    seq_w.delete(); seq_k.delete();
    seq_w.push_back(W_FETCH); seq_k.push_back(K_FW);
    seq_w.push_back(W_DEC);   seq_k.push_back(K_ONE);
    case (op)
      OP_LW: begin
        seq_w.push_back(W_MADR); seq_k.push_back(K_ONE);
        seq_w.push_back(W_MRD);  seq_k.push_back(K_MW);
        seq_w.push_back(W_MWB);  seq_k.push_back(K_ONE);
      end
      OP_SW: begin
        seq_w.push_back(W_MADR); seq_k.push_back(K_ONE);
        seq_w.push_back(W_MWR);  seq_k.push_back(K_SW);
      end
      OP_R: begin
        seq_w.push_back(W_EXEC); seq_k.push_back(K_ONE);
        seq_w.push_back(W_AWB);  seq_k.push_back(K_ONE);
      end
      OP_BEQ: begin
        seq_w.push_back(W_BR);   seq_k.push_back(K_ONE);
      end
      OP_J: begin
        seq_w.push_back(W_J);    seq_k.push_back(K_ONE);
      end
      OP_ADDI: begin
        seq_w.push_back(W_AEX);  seq_k.push_back(K_ONE);
        seq_w.push_back(W_AIWB); seq_k.push_back(K_ONE);
      end
      default: seq_w[1] = W_DEC | M_ILL;
    endcase
  endtask

  // Runs one instruction from its first FETCH cycle, comparing every cycle.
  // Entered and left at 1 ns after a rising edge.
  task automatic run_instr(input logic [5:0] op, input string tag);
    int          idx = 0;
    int          cnt = 0;
    int          guard = 0;
    bit          fin = 0;
    bit          r;
    logic [18:0] exp_w, got;
    build_seq(op);
    while (!fin) begin
      if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
      else if (rand_rdy)      r = ($urandom_range(0, 3) != 0);
      else                    r = 1'b1;
      ctl.memReady = r;
      ctl.opCode   = (idx == 1) ? op : 6'($urandom);
      exp_w = seq_w[idx];
      if (seq_k[idx] == K_ONE) begin
        idx++;
      end else if (r) begin
        if (seq_k[idx] == K_FW) exp_w = exp_w | M_IRW | M_PCW;
        if (seq_k[idx] == K_SW) exp_w = exp_w | M_DONE;
        idx++;
        cnt = 0;
      end else if (cnt == LIM) begin
        exp_w = exp_w | M_MERR;
        fin = 1;
      end else begin
        cnt++;
      end
      if (idx == seq_w.size()) fin = 1;
      g_cyc++;
      @(negedge clk);
      got = obs_w();
      checks++;
      if (got !== exp_w) begin
        failures++;
        $display("FAIL %s cyc%0d op=%b: got %b want %b", tag, g_cyc, op, got, exp_w);
      end
      if (got[16]) g_irw++;
      if (got[13]) g_mwr++;
      if (got[0])  g_merr++;
      if (got[1])  g_ill++;
      if (got[10]) g_rw++;
      if (got[18]) g_pcw++;
      if (got[14] && got[15]) g_mrd++;
      if (got[2])  done_q.push_back(g_cyc);
      @(posedge clk); #1;
      guard++;
      if (guard > 100 && !fin) begin
        failures++;
        $display("FAIL %s: instruction did not finish within cycle budget", tag);
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctl.memReady = 1'b1;
    ctl.opCode   = OP_R;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs_w() !== 19'd0) begin
        failures++;
        $display("FAIL reset_outputs: got %b want 0", obs_w());
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    clr(); rand_rdy = 0; rdy_pat.delete();
    run_instr(OP_R, "rtype");
    checks++;
    if (g_cyc != 4 || done_q.size() != 1 || done_q[0] != 4) begin
      failures++;
      $display("FAIL rtype_latency: got %0d cycles want 4", g_cyc);
    end
  endtask

  task automatic test_lw_wait();
    clr(); rand_rdy = 0;
    rdy_pat = '{1, 1, 1, 0, 0, 0, 1, 1};
    run_instr(OP_LW, "lw_wait");
    checks++;
    if (g_cyc != 8 || g_irw != 1 || g_mrd != 4) begin
      failures++;
      $display("FAIL lw_wait_counts: got cyc=%0d irw=%0d rd=%0d want 8 1 4", g_cyc, g_irw, g_mrd);
    end
  endtask

  task automatic test_back_to_back();
    clr(); rand_rdy = 0; rdy_pat.delete();
    run_instr(OP_SW,  "b2b_sw");
    run_instr(OP_BEQ, "b2b_beq");
    run_instr(OP_J,   "b2b_j");
    checks++;
    if (done_q.size() != 3 || done_q[0] != 4 || done_q[1] != 7 || done_q[2] != 10 || g_mwr != 1) begin
      failures++;
      $display("FAIL b2b_done_pos: got n=%0d mwr=%0d want done at 4,7,10 mwr=1", done_q.size(), g_mwr);
    end
  endtask

  task automatic test_illegal();
    clr(); rand_rdy = 0; rdy_pat.delete();
    run_instr(6'b111111, "illegal");
    checks++;
    if (g_cyc != 2 || g_ill != 1 || g_rw != 0 || g_mwr != 0 || g_pcw != 1) begin
      failures++;
      $display("FAIL illegal_counts: got cyc=%0d ill=%0d rw=%0d mw=%0d pcw=%0d want 2 1 0 0 1",
               g_cyc, g_ill, g_rw, g_mwr, g_pcw);
    end
  endtask

  task automatic test_timeout();
    clr(); rand_rdy = 0;
    rdy_pat = '{0, 0, 0, 0};
    run_instr(OP_J, "to_fetch");
    checks++;
    if (g_cyc != 4 || g_merr != 1 || g_irw != 0) begin
      failures++;
      $display("FAIL timeout_fetch: got cyc=%0d merr=%0d irw=%0d want 4 1 0", g_cyc, g_merr, g_irw);
    end
    clr();
    rdy_pat = '{0, 0, 0, 1};
    run_instr(OP_J, "to_edge");
    checks++;
    if (g_cyc != 6 || g_merr != 0 || g_irw != 1) begin
      failures++;
      $display("FAIL timeout_edge: got cyc=%0d merr=%0d irw=%0d want 6 0 1", g_cyc, g_merr, g_irw);
    end
    clr();
    rdy_pat = '{1, 1, 1, 0, 0, 0, 0};
    run_instr(OP_SW, "to_memwr");
    checks++;
    if (g_cyc != 7 || g_merr != 1 || g_mwr != 4 || done_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_memwr: got cyc=%0d merr=%0d mw=%0d done=%0d want 7 1 4 0",
               g_cyc, g_merr, g_mwr, done_q.size());
    end
    clr();
    run_instr(OP_ADDI, "after_to");
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    clr(); rand_rdy = 1; rdy_pat.delete();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, "random");
    end
    rand_rdy = 0;
  endtask

  task automatic test_async_reset();
    rdy_pat.delete(); rand_rdy = 0;
    ctl.memReady = 1'b1;
    ctl.opCode   = OP_SW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctl.memReady = 1'b0;
    #1;
    checks++;
    if (ctl.memWrite !== 1'b1) begin
      failures++;
      $display("FAIL ar_in_memwr: got memWrite=%b want 1", ctl.memWrite);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_w() !== 19'd0) begin
      failures++;
      $display("FAIL ar_async_zero: got %b want 0", obs_w());
    end
    @(posedge clk); #1;
    checks++;
    if (obs_w() !== 19'd0) begin
      failures++;
      $display("FAIL ar_held_zero: got %b want 0", obs_w());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_w() !== W_FETCH) begin
      failures++;
      $display("FAIL ar_release_fetch: got %b want %b", obs_w(), W_FETCH);
    end
    clr();
    run_instr(OP_LW, "after_ar");
    checks++;
    if (g_cyc != 5) begin
      failures++;
      $display("FAIL ar_recover_lw: got %0d cycles want 5", g_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle MIPS control unit, successor to the single-cycle opcode decoder. A Moore/Mealy FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps and drives the shared-ALU, shared-memory datapath controls. Supports R-type, lw, sw, beq, j and addi, with an optional memory ready handshake and a wait timeout. Sits between the instruction register opcode field and the multi-cycle datapath.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for memReady; 0 = memReady ignored and treated as 1.
WAIT_LIMIT, 15, maximum wait cycles with memReady=0 before memError; 0 disables the timeout. Counter width is clog2(WAIT_LIMIT+1).
ALUOP_W, 2, ALUop width; encodings occupy the low 2 bits and the upper bits are 0.

Ports:
clk  in  1  clock; all state changes occur on the rising edge
rst_n  in  1  asynchronous, active-low reset
opCode  in  6  instruction opcode, sampled in DECODE
memReady  in  1  memory access complete this cycle
pcWrite  out  1  unconditional PC load
branch  out  1  PC load qualified by ALU zero
irWrite  out  1  instruction register load
iorD  out  1  memory address select: 0 = PC, 1 = ALU out
memRead  out  1  memory read request
memWrite  out  1  memory write request
memToReg  out  1  register write data select: 1 = memory data
regDst  out  1  destination register select: 1 = rd
regWrite  out  1  register file write
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs
ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUop  out  ALUOP_W  00 = add, 01 = sub, 10 = funct
PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
instrDone  out  1  one-cycle pulse in the final cycle of each instruction
illegalOp  out  1  one-cycle pulse: undefined opcode decoded
memError  out  1  one-cycle pulse: memory wait timeout

Behaviour:
- Reset: the state register goes to FETCH and the wait counter clears asynchronously. All outputs are forced to 0 while rst_n=0. The first FETCH cycle follows the first clock edge after release.
- Every output not listed for a state is 0.
- FETCH: memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00. irWrite and pcWrite are set to memReady (Mealy). On memReady the FSM moves to DECODE; otherwise it stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opCode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP. Any other opCode pulses illegalOp and returns to FETCH; no register or memory writes occur.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state is MEMRD for lw and MEMWR for sw, using the opcode latched in DECODE.
- MEMRD: iorD=1, memRead=1. Stays until memReady, then goes to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1, instrDone=1. Next state FETCH.
- MEMWR: iorD=1, memWrite=1, held until memReady. On memReady, instrDone=1 and the FSM goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next state ALUWB.
- ALUWB: regDst=1, regWrite=1, instrDone=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01, branch=1, instrDone=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1, instrDone=1. Next state FETCH.
- JUMP: PCSrc=10, pcWrite=1, instrDone=1. Next state FETCH.
- opCode is latched into an internal register in DECODE; later changes on opCode are ignored.
- Latency with memReady always 1, counted in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle in those states while memReady=0.
  - If the counter equals WAIT_LIMIT and memReady=0, memError pulses and the FSM goes to FETCH with no irWrite/pcWrite/regWrite. memWrite drops the next cycle.
  - If memReady=1 in the limit cycle, memReady wins and there is no error.
- MEM_HANDSHAKE=0: the wait states always exit after 1 cycle and memError never asserts.
- Asynchronous reset mid-instruction aborts it immediately; no write strobe survives the reset assertion.

Test Plan:
- Reset, then memReady=1, opCode=000000 -> states FETCH, DECODE, EXEC, ALUWB. ALUWB shows regDst=1, regWrite=1, instrDone=1; EXEC shows ALUop=10; total 4 cycles.
- lw (100011) with memReady low for 3 cycles in MEMRD -> memRead/iorD=1 held for 4 cycles, then MEMWB with memToReg=1, regWrite=1. Total 8 cycles; exactly one irWrite pulse.
- sw (101011), then beq (000100), then j (000010) back-to-back with memReady=1 -> sw completes in 4 cycles with memWrite=1 for 1 cycle. BRANCH shows branch=1, PCSrc=01, ALUop=01. JUMP shows pcWrite=1, PCSrc=10. instrDone pulses at cycles 4, 7 and 10.
- opCode=111111 -> illegalOp pulses in DECODE, FSM returns to FETCH, and regWrite, memWrite and pcWrite stay 0 apart from the FETCH pcWrite.
- WAIT_LIMIT=3 with memReady stuck 0 in FETCH -> memError pulses in the 4th FETCH cycle, FSM re-enters FETCH, irWrite never asserts. Repeat with memReady=1 exactly in the limit cycle -> no memError and the FSM moves to DECODE.
- Deassert rst_n during MEMWR -> all outputs go to 0 asynchronously. After release, the FSM is in FETCH with memRead=1.
